// File: rtl/sm_pkg.sv
// Shared sign-magnitude helpers for the arithmetic library.
// Provides the add/sub op encoding, sign/magnitude split helpers that work on
// any word width up to SM_MAX_W, and negative-zero canonicalisation.
package sm_pkg;

    localparam int unsigned SM_MAX_W = 64;

    typedef logic [SM_MAX_W-1:0] sm_word_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Sign bit of a w-bit sign-magnitude word held in the low bits of x.
    function automatic logic sm_sign(input sm_word_t x, input int unsigned w);
        return |((x >> (w - 1)) & sm_word_t'(1));
    endfunction

    // Magnitude field (low w-1 bits) of a w-bit sign-magnitude word.
    function automatic sm_word_t sm_mag(input sm_word_t x, input int unsigned w);
        return x & ((sm_word_t'(1) << (w - 1)) - sm_word_t'(1));
    endfunction

    // Negative zero collapses to +0.
    function automatic logic sm_canon_sign(input logic sign, input logic mag_zero);
        return sign & ~mag_zero;
    endfunction

endpackage

// File: rtl/sm_mag_sort.sv
// Magnitude compare-and-swap for a sign-magnitude add/sub.
// Ports:
//   a_sign, a_mag   first operand (already canonicalised)
//   b_sign, b_mag   second operand, sign already adjusted for subtraction
//   max_c, min_c    larger / smaller magnitude
//   sign_r_c        sign of the larger magnitude (sign of A on a tie)
//   eff_sub_c       1 when the operand signs differ (magnitudes subtract)
module sm_mag_sort #(
    parameter int unsigned M = 7
) (
    input  logic         a_sign,
    input  logic [M-1:0] a_mag,
    input  logic         b_sign,
    input  logic [M-1:0] b_mag,
    output logic [M-1:0] max_c,
    output logic [M-1:0] min_c,
    output logic         sign_r_c,
    output logic         eff_sub_c
);

    logic a_ge;

    // Ties go to A so equal magnitudes keep A's sign.
    assign a_ge      = (a_mag >= b_mag);
    assign max_c     = a_ge ? a_mag : b_mag;
    assign min_c     = a_ge ? b_mag : a_mag;
    assign sign_r_c  = a_ge ? a_sign : b_sign;
    assign eff_sub_c = (a_sign != b_sign);

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage pipelined sign-magnitude adder/subtractor with saturation and an
// optional running accumulator.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_valid/in_ready      operand handshake (in_ready is combinational)
//   a, b, op               operands; op 0 = a+b, 1 = a-b
//   acc_mode, acc_clr      use accumulator as A; clear accumulator
//   out_valid/out_ready    result handshake
//   sum, ovf, zero         registered result, saturation flag, zero flag
module sm_addsub_pipe
    import sm_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op,
    input  logic         acc_mode,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         ovf,
    output logic         zero
);

    localparam int unsigned M = N - 1;

    logic [N-1:0] acc;
    logic [N-1:0] opa;
    logic         a_sign;
    logic         b_sign;
    logic [M-1:0] a_mag;
    logic [M-1:0] b_mag;

    logic [M-1:0] srt_max;
    logic [M-1:0] srt_min;
    logic         srt_sign;
    logic         srt_eff_sub;

    logic         s1_valid;
    logic [M-1:0] s1_max;
    logic [M-1:0] s1_min;
    logic         s1_sign;
    logic         s1_eff_sub;
    logic         s1_acc;

    logic         adv2;
    logic         s1_adv;
    logic         in_fire;

    logic [M:0]   mag_raw;
    logic         r_ovf;
    logic [M-1:0] r_mag;
    logic         r_zero;
    logic [N-1:0] r_word;

    // Handshake and stage-advance control.
    assign adv2     = !out_valid || out_ready;
    assign s1_adv   = s1_valid && adv2;
    assign in_ready = (!s1_valid || adv2) && !(acc_mode && s1_valid) && !reset;
    assign in_fire  = in_valid && in_ready;

    // Effective A: a clear in the same cycle means the accumulator reads as 0.
    assign opa    = acc_mode ? (acc_clr ? '0 : acc) : a;
    assign a_mag  = M'(sm_mag(SM_MAX_W'(opa), N));
    assign b_mag  = M'(sm_mag(SM_MAX_W'(b), N));
    assign a_sign = sm_canon_sign(sm_sign(SM_MAX_W'(opa), N), (a_mag == '0));
    assign b_sign = sm_canon_sign(sm_sign(SM_MAX_W'(b), N), (b_mag == '0)) ^ (op != OP_ADD);

    sm_mag_sort #(
        .M (M)
    ) u_sort (
        .a_sign    (a_sign),
        .a_mag     (a_mag),
        .b_sign    (b_sign),
        .b_mag     (b_mag),
        .max_c     (srt_max),
        .min_c     (srt_min),
        .sign_r_c  (srt_sign),
        .eff_sub_c (srt_eff_sub)
    );

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_max     <= '0;
            s1_min     <= '0;
            s1_sign    <= 1'b0;
            s1_eff_sub <= 1'b0;
            s1_acc     <= 1'b0;
        end else if (in_fire) begin
            s1_valid   <= 1'b1;
            s1_max     <= srt_max;
            s1_min     <= srt_min;
            s1_sign    <= srt_sign;
            s1_eff_sub <= srt_eff_sub;
            s1_acc     <= acc_mode;
        end else if (s1_adv) begin
            s1_valid   <= 1'b0;
        end
    end

    // Stage 2 arithmetic; max >= min so subtraction never borrows.
    always_comb begin
        mag_raw = '0;
        if (s1_eff_sub) begin
            mag_raw = {1'b0, s1_max} - {1'b0, s1_min};
        end else begin
            mag_raw = {1'b0, s1_max} + {1'b0, s1_min};
        end
    end

    assign r_ovf  = mag_raw[M];
    assign r_mag  = r_ovf ? '1 : mag_raw[M-1:0];
    assign r_zero = (r_mag == '0);
    assign r_word = {s1_sign & ~r_zero, r_mag};

    // Output register; holds while stalled, reloads without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            sum       <= r_word;
            ovf       <= r_ovf;
            zero      <= r_zero;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator: clear beats a load from an acc op entering stage 2.
    always_ff @(posedge clk) begin
        if (reset || acc_clr) begin
            acc <= '0;
        end else if (s1_adv && s1_acc) begin
            acc <= r_word;
        end
    end

endmodule
